br_wb_queue: RTL and testbench
==============================

Name: br_wb_queue

Overview:
- Write-side initiator for the register bank (32 x 32-bit, combinational read, level-sensitive write on RegEn).
- Accepts writeback requests from the datapath over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one register-bank write per cycle on registered outputs, so the bank write port never sees combinational glitches.
- Provides a pending-write lookup on both read addresses so the datapath can forward values that have not yet been written.

Parameters:
- DEPTH, 4, FIFO entries; power of two, range 2..16.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_valid  in  1  writeback request valid.
- wb_ready  out  1  queue can accept a request.
- wb_addr  in  AW  destination register.
- wb_data  in  DW  value to write.
- br_stall  in  1  bank write port unavailable; hold the queue.
- br_wr_en  out  1  drives bank RegEn.
- br_wr_addr  out  AW  drives bank WriteRegister.
- br_wr_data  out  DW  drives bank WriteData.
- rd_addr1  in  AW  datapath ReadRegister1 (lookup).
- rd_addr2  in  AW  datapath ReadRegister2 (lookup).
- pend_hit1  out  1  a queued write targets rd_addr1.
- pend_data1  out  DW  youngest queued data for rd_addr1.
- pend_hit2  out  1  a queued write targets rd_addr2.
- pend_data2  out  DW  youngest queued data for rd_addr2.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async): rd_ptr = 0, wr_ptr = 0, count = 0, br_wr_en = 0, br_wr_addr = 0, br_wr_data = 0. All entry valid bits clear, so pend_hit1/2 = 0.
- Handshake:
  - wb_ready = (count < DEPTH), combinational from count only; it does not depend on a same-cycle pop.
  - Push occurs on an edge where wb_valid && wb_ready. wb_addr and wb_data are captured at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs on an edge where count > 0 && !br_stall.
  - The head entry loads br_wr_addr/br_wr_data, br_wr_en is set to 1, and rd_ptr wraps modulo DEPTH.
  - On any other edge br_wr_en = 0, and br_wr_addr/br_wr_data hold their values.
- br_wr_en is therefore a one-cycle pulse per popped entry. Back-to-back pops give continuous high.
- Latency: a request pushed at edge E is popped at edge E+1 at the earliest, so br_wr_en is high in the cycle after E+1. Requests are never reordered.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Full with push attempt: the push is ignored (wb_ready = 0). The upstream source must hold valid.
- Empty: no pop; br_wr_en = 0 regardless of br_stall.
- br_stall asserted: no pop; pushes continue until full.
- Lookup (combinational):
  - Scan the valid FIFO entries from youngest to oldest. The first entry whose address equals rd_addrN sets pend_hitN = 1 and drives pend_dataN.
  - With no match, pend_hitN = 0 and pend_dataN = 0.
  - The output register (the in-flight write) is excluded; the bank's combinational write makes that value visible the same cycle.
- Reset mid-operation: the queue is flushed immediately; queued writes are lost and br_wr_en drops asynchronously.
- Register 0 is not special unless the optional feature is enabled.

Optional Feature:
- Macro: BR_WB_ZERO_DROP_EN.
- Defined:
  - A handshake with wb_addr == 0 completes (wb_ready follows the normal rule) but nothing is enqueued; count is unchanged.
  - Lookups for rd_addr == 0 always return pend_hit = 0.
- Undefined: register 0 is queued and written like any other register.

Decomposition:
- Shared package br_pkg: AW, DW, and the constant REG_ZERO = 5'd0.
- One natural sub-module: br_wb_fifo (storage, pointers, count, per-entry valid). It exposes its entry arrays for the lookup.
- The top level holds the output register, pop control, and the lookup priority logic.

Test Plan:
- Single write: push addr 3 / data 32'hDEADBEEF with br_stall = 0 -> br_wr_en high for exactly one cycle, two edges after the push, with addr 3 and data DEADBEEF; count returns to 0.
- Fill under stall: br_stall = 1, push addr 1..4 / data 10..13 -> wb_ready = 0 after 4 pushes and count = 4. A fifth push is rejected and held. Release stall -> four consecutive br_wr_en cycles in order 1..4, then the held fifth request drains.
- Simultaneous push/pop at count = 2 -> count stays 2; output order is preserved across pointer wrap (run more than 2 x DEPTH writes).
- Forwarding: queue addr 7 = 5, then addr 7 = 9, with stall held; rd_addr1 = 7 -> pend_hit1 = 1, pend_data1 = 9. With rd_addr2 = 8 -> pend_hit2 = 0 and pend_data2 = 0.
- Async reset with 3 entries queued and br_wr_en high -> all outputs drop to 0 before the next edge; no writes are issued after reset release.
- With BR_WB_ZERO_DROP_EN defined: push addr 0 -> handshake completes, count stays 0, no br_wr_en, pend_hit = 0 for rd_addr 0. Without the macro the same push produces a write to addr 0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared widths and constants for the register-bank writeback path.
package br_pkg;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/br_wb_queue_if.sv
// Writeback request, bank write port and forwarding lookup bundle for br_wb_queue.
interface br_wb_queue_if
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW = br_pkg::AW,
    parameter int unsigned DW = br_pkg::DW,
    localparam int unsigned CW = $clog2(DEPTH) + 1
);
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          br_stall;
    logic          br_wr_en;
    logic [AW-1:0] br_wr_addr;
    logic [DW-1:0] br_wr_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          pend_hit1;
    logic [DW-1:0] pend_data1;
    logic          pend_hit2;
    logic [DW-1:0] pend_data2;
    logic [CW-1:0] count;

    modport slave (
        input  wb_valid, wb_addr, wb_data, br_stall, rd_addr1, rd_addr2,
        output wb_ready, br_wr_en, br_wr_addr, br_wr_data,
               pend_hit1, pend_data1, pend_hit2, pend_data2, count
    );

    modport master (
        output wb_valid, wb_addr, wb_data, br_stall, rd_addr1, rd_addr2,
        input  wb_ready, br_wr_en, br_wr_addr, br_wr_data,
               pend_hit1, pend_data1, pend_hit2, pend_data2, count
    );
endinterface

// File: rtl/br_wb_queue_fifo.sv
// Writeback FIFO storage: pointers, occupancy and per-entry valid bits.
// Entry arrays are exposed so the parent can run the pending-write lookup.
module br_wb_fifo
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW = br_pkg::AW,
    parameter int unsigned DW = br_pkg::DW,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] pushAddr,
    input  logic [DW-1:0] pushData,
    input  logic          pop,
    output logic [AW-1:0] headAddr,
    output logic [DW-1:0] headData,
    output logic [PW-1:0] rdPtr,
    output logic [CW-1:0] count,
    output logic [AW-1:0] entryAddr [DEPTH],
    output logic [DW-1:0] entryData [DEPTH],
    output logic [DEPTH-1:0] entryValid
);
    logic [PW-1:0] wrPtr;

    assign headAddr = entryAddr[rdPtr];
    assign headData = entryData[rdPtr];

    // Push and pop never target the same slot: the parent only pushes when
    // not full and only pops when not empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
        end else begin
            if (pop) begin
                rdPtr             <= rdPtr + PW'(1);
                entryValid[rdPtr] <= 1'b0;
            end
            if (push) begin
                wrPtr             <= wrPtr + PW'(1);
                entryValid[wrPtr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entryAddr[wrPtr] <= pushAddr;
            entryData[wrPtr] <= pushData;
        end
    end
endmodule

// File: rtl/br_wb_queue.sv
// Register-bank writeback queue: buffered requests, registered bank write port,
// pending-write forwarding lookup. Optional macro BR_WB_ZERO_DROP_EN drops writes to register 0.
module br_wb_queue
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW = br_pkg::AW,
    parameter int unsigned DW = br_pkg::DW,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input logic clk,
    input logic rst,
    br_wb_queue_if.slave bus
);
    logic          accept;
    logic          push;
    logic          pop;
    logic [AW-1:0] headAddr;
    logic [DW-1:0] headData;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [AW-1:0] entryAddr [DEPTH];
    logic [DW-1:0] entryData [DEPTH];
    logic [DEPTH-1:0] entryValid;

    assign bus.count    = count;
    assign bus.wb_ready = (count < CW'(DEPTH));
    assign accept       = bus.wb_valid && bus.wb_ready;
    assign pop          = (count != '0) && !bus.br_stall;

`ifdef BR_WB_ZERO_DROP_EN
    assign push = accept && (bus.wb_addr != REG_ZERO);
`else
    assign push = accept;
`endif

    br_wb_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pushAddr  (bus.wb_addr),
        .pushData  (bus.wb_data),
        .pop       (pop),
        .headAddr  (headAddr),
        .headData  (headData),
        .rdPtr     (rdPtr),
        .count     (count),
        .entryAddr (entryAddr),
        .entryData (entryData),
        .entryValid(entryValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.br_wr_en   <= 1'b0;
            bus.br_wr_addr <= '0;
            bus.br_wr_data <= '0;
        end else begin
            bus.br_wr_en <= pop;
            if (pop) begin
                bus.br_wr_addr <= headAddr;
                bus.br_wr_data <= headData;
            end
        end
    end

    // Walk oldest to youngest from the head; later matches override, so the
    // youngest queued write wins.
    always_comb begin
        bus.pend_hit1  = 1'b0;
        bus.pend_data1 = '0;
        bus.pend_hit2  = 1'b0;
        bus.pend_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = rdPtr + PW'(i);
            if (entryValid[idx] && (entryAddr[idx] == bus.rd_addr1)) begin
                bus.pend_hit1  = 1'b1;
                bus.pend_data1 = entryData[idx];
            end
            if (entryValid[idx] && (entryAddr[idx] == bus.rd_addr2)) begin
                bus.pend_hit2  = 1'b1;
                bus.pend_data2 = entryData[idx];
            end
        end
`ifdef BR_WB_ZERO_DROP_EN
        if (bus.rd_addr1 == REG_ZERO) begin
            bus.pend_hit1  = 1'b0;
            bus.pend_data1 = '0;
        end
        if (bus.rd_addr2 == REG_ZERO) begin
            bus.pend_hit2  = 1'b0;
            bus.pend_data2 = '0;
        end
`endif
    end
endmodule

// File: tb/tb_br_wb_queue.sv
// Scoreboard bench for br_wb_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honours BR_WB_ZERO_DROP_EN.
module tb_br_wb_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    br_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    br_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned nChecks = 0;
    int unsigned nPass = 0;

    req_t          pendQ[$];   // accepted, not yet popped
    req_t          expQ[$];    // accepted, write not yet observed
    logic          mWrEn = 1'b0;
    logic [AW-1:0] mRegAddr = '0;
    logic [DW-1:0] mRegData = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
`ifdef BR_WB_ZERO_DROP_EN
        if (a == '0) return;
`endif
        for (int i = int'(pendQ.size()) - 1; i >= 0; i--) begin
            if (pendQ[i].addr == a) begin
                h = 1'b1;
                d = pendQ[i].data;
                break;
            end
        end
    endfunction

    // Reference model: a FIFO of accepted requests drained one per unstalled cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pendQ.delete();
            expQ.delete();
            mWrEn    = 1'b0;
            mRegAddr = '0;
            mRegData = '0;
        end else begin
            logic doPop, doPush;
            req_t r;
            doPop  = (pendQ.size() > 0) && !bus.br_stall;
            doPush = bus.wb_valid && (pendQ.size() < DEPTH);
            mWrEn  = doPop;
            if (doPop) begin
                r = pendQ.pop_front();
                mRegAddr = r.addr;
                mRegData = r.data;
            end
`ifdef BR_WB_ZERO_DROP_EN
            if (bus.wb_addr == '0) doPush = 1'b0;
`endif
            if (doPush) begin
                r.addr = bus.wb_addr;
                r.data = bus.wb_data;
                pendQ.push_back(r);
                expQ.push_back(r);
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        logic h;
        logic [DW-1:0] d;
        req_t e;
        check("wb_ready", 32'(bus.wb_ready), 32'(pendQ.size() < DEPTH));
        check("count", 32'(bus.count), 32'(pendQ.size()));
        check("br_wr_en", 32'(bus.br_wr_en), 32'(mWrEn));
        check("br_wr_addr_reg", 32'(bus.br_wr_addr), 32'(mRegAddr));
        check("br_wr_data_reg", bus.br_wr_data, mRegData);
        if (bus.br_wr_en) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", 32'(bus.br_wr_en), 32'(0));
            end else begin
                e = expQ.pop_front();
                check("sb_addr", 32'(bus.br_wr_addr), 32'(e.addr));
                check("sb_data", bus.br_wr_data, e.data);
            end
        end
        lookup(bus.rd_addr1, h, d);
        check("pend_hit1", 32'(bus.pend_hit1), 32'(h));
        check("pend_data1", bus.pend_data1, d);
        lookup(bus.rd_addr2, h, d);
        check("pend_hit2", 32'(bus.pend_hit2), 32'(h));
        check("pend_data2", bus.pend_data2, d);
    end

    // Called at negedge+1; holds valid until accepted or the budget runs out.
    task automatic pushOne(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned n = 0;
        logic acc = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        while (!acc && n < 40) begin
            acc = bus.wb_ready;
            @(posedge clk);
            @(negedge clk);
            #1;
            n++;
        end
        bus.wb_valid = 1'b0;
        if (!acc) check("push_timeout", 32'(acc), 32'(1));
    endtask

    task automatic drain();
        bus.br_stall = 1'b0;
        bus.wb_valid = 1'b0;
        repeat (DEPTH + 4) @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.br_stall = 1'b0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_wr_en", 32'(bus.br_wr_en), 32'(0));
        check("rst_count", 32'(bus.count), 32'(0));
        check("rst_wr_addr", 32'(bus.br_wr_addr), 32'(0));
        check("rst_wr_data", bus.br_wr_data, 32'(0));
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Single write
        bus.rd_addr1 = 5'd3;
        bus.rd_addr2 = 5'd4;
        pushOne(5'd3, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("single_en", 32'(bus.br_wr_en), 32'(1));
        check("single_addr", 32'(bus.br_wr_addr), 32'(3));
        check("single_data", bus.br_wr_data, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("single_en_pulse", 32'(bus.br_wr_en), 32'(0));
        check("single_count", 32'(bus.count), 32'(0));
        drain();

        // Fill under stall, fifth request held then drained
        bus.br_stall = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) pushOne(AW'(i), DW'(i + 9));
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 32'd14;
        repeat (3) @(negedge clk);
        #1;
        check("full_ready", 32'(bus.wb_ready), 32'(0));
        check("full_count", 32'(bus.count), 32'(4));
        bus.br_stall = 1'b0;
        pushOne(5'd5, 32'd14);
        drain();

        // Simultaneous push/pop at count 2, across pointer wrap
        bus.br_stall = 1'b1;
        pushOne(5'd9, 32'h900);
        pushOne(5'd10, 32'hA00);
        bus.br_stall = 1'b0;
        for (int unsigned i = 0; i < 2 * DEPTH + 3; i++) pushOne(AW'(11 + i), $urandom);
        check("steady_count", 32'(bus.count), 32'(2));
        drain();

        // Forwarding: youngest write to the same register wins
        bus.br_stall = 1'b1;
        pushOne(5'd7, 32'd5);
        pushOne(5'd7, 32'd9);
        bus.rd_addr1 = 5'd7;
        bus.rd_addr2 = 5'd8;
        #1;
        check("fwd_hit1", 32'(bus.pend_hit1), 32'(1));
        check("fwd_data1", bus.pend_data1, 32'd9);
        check("fwd_hit2", 32'(bus.pend_hit2), 32'(0));
        check("fwd_data2", bus.pend_data2, 32'd0);
        @(negedge clk); #1;
        drain();

        // Randomized traffic
        for (int unsigned c = 0; c < 400; c++) begin
            bus.wb_valid = ($urandom_range(0, 9) < 6);
            bus.wb_addr  = AW'($urandom_range(0, 7));
            bus.wb_data  = $urandom;
            bus.br_stall = ($urandom_range(0, 3) == 0);
            bus.rd_addr1 = AW'($urandom_range(0, 7));
            bus.rd_addr2 = AW'($urandom_range(0, 7));
            @(negedge clk);
            #1;
        end
        drain();

        // Async reset with entries queued and a write in flight
        bus.br_stall = 1'b1;
        for (int unsigned i = 0; i < 4; i++) pushOne(AW'(20 + i), DW'(32'h100 + i));
        bus.rd_addr1 = 5'd22;
        bus.rd_addr2 = 5'd23;
        bus.br_stall = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_en", 32'(bus.br_wr_en), 32'(1));
        rst = 1'b1;
        #1;
        check("arst_en", 32'(bus.br_wr_en), 32'(0));
        check("arst_addr", 32'(bus.br_wr_addr), 32'(0));
        check("arst_data", bus.br_wr_data, 32'(0));
        check("arst_count", 32'(bus.count), 32'(0));
        check("arst_hit1", 32'(bus.pend_hit1), 32'(0));
        check("arst_hit2", 32'(bus.pend_hit2), 32'(0));
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;

        // Register 0 handling
        bus.rd_addr1 = 5'd0;
        bus.br_stall = 1'b1;
        pushOne(5'd0, 32'h1234);
        bus.br_stall = 1'b0;
        drain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
